// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Value-capturing, collapsing reservation station in front of the ALU.
//   Slot 0 always holds the oldest entry. Each cycle the lowest-index entry
//   with both operands captured is selected from registered state, and its
//   fields are registered onto the issue_* outputs at the next edge, where
//   it is also removed. Younger entries shift down to fill the gap, and a
//   dispatch accepted on the same edge lands in the first free slot after
//   that shift.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   disp_*          : one renamed instruction per cycle; accepted when
//                     disp_valid && disp_ready
//   wb_valid/pd/data: writeback broadcast used for operand wakeup
//   issue_*         : registered ALU inputs; issue_valid marks a new issue
//   count           : number of occupied entries
module alu_issue_queue #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6,
    parameter int XLEN   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [6:0]                 disp_opcode,
    input  logic [2:0]                 disp_func3,
    input  logic [6:0]                 disp_func7,
    input  logic [PREG_W-1:0]          disp_ps1,
    input  logic                       disp_ps1_rdy,
    input  logic [XLEN-1:0]            disp_ps1_data,
    input  logic [PREG_W-1:0]          disp_ps2,
    input  logic                       disp_ps2_rdy,
    input  logic [XLEN-1:0]            disp_ps2_data,
    input  logic                       disp_use_imm,
    input  logic [XLEN-1:0]            disp_imm,
    input  logic [PREG_W-1:0]          disp_pd,
    input  logic                       wb_valid,
    input  logic [PREG_W-1:0]          wb_pd,
    input  logic [XLEN-1:0]            wb_data,
    output logic                       issue_valid,
    output logic [6:0]                 issue_opcode,
    output logic [2:0]                 issue_func3,
    output logic [6:0]                 issue_func7,
    output logic [XLEN-1:0]            issue_source_1,
    output logic [XLEN-1:0]            issue_source_2,
    output logic [PREG_W-1:0]          issue_pd,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic [PREG_W-1:0] tag;
        logic              rdy;
        logic [XLEN-1:0]   data;
    } src_t;

    typedef struct packed {
        logic              valid;
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [PREG_W-1:0] pd;
        src_t              s1;
        src_t              s2;
    } ent_t;

    ent_t          q  [DEPTH];
    ent_t          wk [DEPTH+1];   // extra always-empty slot feeds the top on a shift
    ent_t          nq [DEPTH];
    ent_t          de;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic          accept;
    logic          wb_hit;
    logic [CW-1:0] wr_slot;

    assign disp_ready = (count != CW'(DEPTH));
    assign accept     = disp_valid && disp_ready;
    assign wb_hit     = wb_valid && (wb_pd != '0);
    // Valid entries are contiguous from slot 0, so after an issue the
    // first free slot is one lower.
    assign wr_slot    = count - CW'(sel_found);

    // Oldest ready entry: scanning downward leaves the lowest index last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q[i].valid && q[i].s1.rdy && q[i].s2.rdy) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    // Wakeup of resident entries; both sources may match one broadcast.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk[i] = q[i];
            if (wb_hit && q[i].valid) begin
                if (!q[i].s1.rdy && q[i].s1.tag == wb_pd) begin
                    wk[i].s1.rdy  = 1'b1;
                    wk[i].s1.data = wb_data;
                end
                if (!q[i].s2.rdy && q[i].s2.tag == wb_pd) begin
                    wk[i].s2.rdy  = 1'b1;
                    wk[i].s2.data = wb_data;
                end
            end
        end
        wk[DEPTH] = '0;
    end

    // Incoming entry: tag 0 reads as zero, then a ready value, then a
    // same-cycle broadcast bypass.
    always_comb begin
        de        = '0;
        de.valid  = 1'b1;
        de.opcode = disp_opcode;
        de.func3  = disp_func3;
        de.func7  = disp_func7;
        de.pd     = disp_pd;
        de.s1.tag = disp_ps1;
        de.s2.tag = disp_ps2;
        if (disp_ps1 == '0) begin
            de.s1.rdy = 1'b1;
        end else if (disp_ps1_rdy) begin
            de.s1.rdy  = 1'b1;
            de.s1.data = disp_ps1_data;
        end else if (wb_hit && wb_pd == disp_ps1) begin
            de.s1.rdy  = 1'b1;
            de.s1.data = wb_data;
        end
        if (disp_use_imm) begin
            de.s2.rdy  = 1'b1;
            de.s2.data = disp_imm;
        end else if (disp_ps2 == '0) begin
            de.s2.rdy = 1'b1;
        end else if (disp_ps2_rdy) begin
            de.s2.rdy  = 1'b1;
            de.s2.data = disp_ps2_data;
        end else if (wb_hit && wb_pd == disp_ps2) begin
            de.s2.rdy  = 1'b1;
            de.s2.data = wb_data;
        end
    end

    // Collapse above the issued slot, then drop the dispatch in.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_found && IW'(i) >= sel_idx) nq[i] = wk[i+1];
            else                                nq[i] = wk[i];
            if (accept && CW'(i) == wr_slot)    nq[i] = de;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count          <= '0;
            issue_valid    <= 1'b0;
            issue_opcode   <= '0;
            issue_func3    <= '0;
            issue_func7    <= '0;
            issue_source_1 <= '0;
            issue_source_2 <= '0;
            issue_pd       <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
            count       <= count + CW'(accept) - CW'(sel_found);
            issue_valid <= sel_found;
            if (sel_found) begin
                issue_opcode   <= q[sel_idx].opcode;
                issue_func3    <= q[sel_idx].func3;
                issue_func7    <= q[sel_idx].func7;
                issue_source_1 <= q[sel_idx].s1.data;
                issue_source_2 <= q[sel_idx].s2.data;
                issue_pd       <= q[sel_idx].pd;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
    localparam int DEPTH = 16, PREG_W = 6, XLEN = 32;

    logic              clk = 0, reset = 1;
    logic              disp_valid, disp_ready, disp_ps1_rdy, disp_ps2_rdy, disp_use_imm;
    logic [6:0]        disp_opcode, disp_func7;
    logic [2:0]        disp_func3;
    logic [PREG_W-1:0] disp_ps1, disp_ps2, disp_pd, wb_pd, issue_pd;
    logic [XLEN-1:0]   disp_ps1_data, disp_ps2_data, disp_imm, wb_data;
    logic              wb_valid, issue_valid;
    logic [6:0]        issue_opcode, issue_func7;
    logic [2:0]        issue_func3;
    logic [XLEN-1:0]   issue_source_1, issue_source_2;
    logic [4:0]        count;

    alu_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_func3(disp_func3), .disp_func7(disp_func7),
        .disp_ps1(disp_ps1), .disp_ps1_rdy(disp_ps1_rdy), .disp_ps1_data(disp_ps1_data),
        .disp_ps2(disp_ps2), .disp_ps2_rdy(disp_ps2_rdy), .disp_ps2_data(disp_ps2_data),
        .disp_use_imm(disp_use_imm), .disp_imm(disp_imm), .disp_pd(disp_pd),
        .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_func3(issue_func3),
        .issue_func7(issue_func7), .issue_source_1(issue_source_1),
        .issue_source_2(issue_source_2), .issue_pd(issue_pd), .count(count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: an ordered list of waiting instructions, oldest first.
    typedef struct {
        bit [6:0] op; bit [2:0] f3; bit [6:0] f7; bit [5:0] pd;
        bit [5:0] t1; bit r1; bit [31:0] d1;
        bit [5:0] t2; bit r2; bit [31:0] d2;
    } ment_t;
    ment_t mq[$];
    bit        e_v;
    bit [6:0]  e_op, e_f7;
    bit [2:0]  e_f3;
    bit [31:0] e_s1, e_s2;
    bit [5:0]  e_pd;

    function automatic void model_update();
        int k = -1;
        int old_n = mq.size();
        ment_t e;
        if (reset) begin
            mq.delete();
            e_v = 0; e_op = 0; e_f3 = 0; e_f7 = 0; e_s1 = 0; e_s2 = 0; e_pd = 0;
            return;
        end
        foreach (mq[i]) if (k < 0 && mq[i].r1 && mq[i].r2) k = i;
        e_v = (k >= 0);
        if (k >= 0) begin
            e_op = mq[k].op; e_f3 = mq[k].f3; e_f7 = mq[k].f7;
            e_s1 = mq[k].d1; e_s2 = mq[k].d2; e_pd = mq[k].pd;
        end
        if (wb_valid && wb_pd != 0)
            foreach (mq[i]) begin
                if (!mq[i].r1 && mq[i].t1 == wb_pd) begin mq[i].r1 = 1; mq[i].d1 = wb_data; end
                if (!mq[i].r2 && mq[i].t2 == wb_pd) begin mq[i].r2 = 1; mq[i].d2 = wb_data; end
            end
        if (k >= 0) mq.delete(k);
        if (disp_valid && old_n != DEPTH) begin
            e.op = disp_opcode; e.f3 = disp_func3; e.f7 = disp_func7; e.pd = disp_pd;
            e.t1 = disp_ps1; e.t2 = disp_ps2;
            if (disp_ps1 == 0) begin e.r1 = 1; e.d1 = 0; end
            else if (disp_ps1_rdy) begin e.r1 = 1; e.d1 = disp_ps1_data; end
            else if (wb_valid && wb_pd == disp_ps1) begin e.r1 = 1; e.d1 = wb_data; end
            else begin e.r1 = 0; e.d1 = 0; end
            if (disp_use_imm) begin e.r2 = 1; e.d2 = disp_imm; end
            else if (disp_ps2 == 0) begin e.r2 = 1; e.d2 = 0; end
            else if (disp_ps2_rdy) begin e.r2 = 1; e.d2 = disp_ps2_data; end
            else if (wb_valid && wb_pd == disp_ps2) begin e.r2 = 1; e.d2 = wb_data; end
            else begin e.r2 = 0; e.d2 = 0; end
            mq.push_back(e);
        end
    endfunction

    task automatic check_all();
        chk("count", count, mq.size());
        chk("disp_ready", disp_ready, mq.size() != DEPTH);
        chk("issue_valid", issue_valid, e_v);
        chk("issue_opcode", issue_opcode, e_op);
        chk("issue_func3", issue_func3, e_f3);
        chk("issue_func7", issue_func7, e_f7);
        chk("issue_source_1", issue_source_1, e_s1);
        chk("issue_source_2", issue_source_2, e_s2);
        chk("issue_pd", issue_pd, e_pd);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        disp_valid = 0; disp_opcode = 0; disp_func3 = 0; disp_func7 = 0;
        disp_ps1 = 0; disp_ps1_rdy = 0; disp_ps1_data = 0;
        disp_ps2 = 0; disp_ps2_rdy = 0; disp_ps2_data = 0;
        disp_use_imm = 0; disp_imm = 0; disp_pd = 0;
        wb_valid = 0; wb_pd = 0; wb_data = 0;
    endtask

    task automatic disp(input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
                        input bit [5:0] p1, input bit r1, input bit [31:0] d1,
                        input bit [5:0] p2, input bit r2, input bit [31:0] d2,
                        input bit imm_en, input bit [31:0] imm, input bit [5:0] pd);
        disp_valid = 1; disp_opcode = op; disp_func3 = f3; disp_func7 = f7;
        disp_ps1 = p1; disp_ps1_rdy = r1; disp_ps1_data = d1;
        disp_ps2 = p2; disp_ps2_rdy = r2; disp_ps2_data = d2;
        disp_use_imm = imm_en; disp_imm = imm; disp_pd = pd;
    endtask

    task automatic bcast(input bit [5:0] pd, input bit [31:0] d);
        wb_valid = 1; wb_pd = pd; wb_data = d;
    endtask

    bit [6:0] ops [8] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                          7'b0010011, 7'b0010011, 7'b0000011, 7'b0100011};
    bit [2:0] f3s [8] = '{3'b000, 3'b000, 3'b100, 3'b101, 3'b000, 3'b111, 3'b010, 3'b010};
    bit [6:0] f7s [8] = '{7'h00, 7'h20, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};

    initial begin
        idle();
        reset = 1;
        step(); step();
        chk("rst_count", count, 0);
        chk("rst_ready", disp_ready, 1);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_pd", issue_pd, 0);
        reset = 0;

        // ADDI x7 = 5 + 3
        disp(7'b0010011, 3'b000, 0, 6'd1, 1, 5, 0, 0, 0, 1, 3, 6'd7);
        step(); idle();
        step();
        chk("addi_valid", issue_valid, 1);
        chk("addi_s1", issue_source_1, 5);
        chk("addi_s2", issue_source_2, 3);
        chk("addi_pd", issue_pd, 7);
        chk("addi_op", issue_opcode, 7'b0010011);
        step();
        chk("addi_after_valid", issue_valid, 0);
        chk("addi_after_count", count, 0);

        // ADD waiting on tag 10; a tag-0 broadcast must not wake it
        disp(7'b0110011, 3'b000, 0, 6'd10, 0, 0, 6'd11, 1, 4, 0, 0, 6'd9);
        step(); idle();
        bcast(0, 32'hdead);
        step(); idle();
        step();
        chk("wb0_no_issue", issue_valid, 0);
        bcast(10, 32'h100);
        step(); idle();
        step();
        chk("wake_valid", issue_valid, 1);
        chk("wake_s1", issue_source_1, 32'h100);
        chk("wake_s2", issue_source_2, 4);
        chk("wake_pd", issue_pd, 9);

        // SUB whose source is broadcast in the dispatch cycle
        disp(7'b0110011, 3'b000, 7'h20, 6'd12, 0, 0, 6'd13, 1, 8, 0, 0, 6'd14);
        bcast(12, 20);
        step(); idle();
        step();
        chk("bypass_valid", issue_valid, 1);
        chk("bypass_s1", issue_source_1, 20);
        chk("bypass_s2", issue_source_2, 8);

        // Ordering: A waits on 3, B and C wait on 4
        disp(7'b0110011, 3'b000, 0, 6'd3, 0, 0, 6'd2, 1, 1, 0, 0, 6'd21); step();
        disp(7'b0010011, 3'b000, 0, 6'd4, 0, 0, 0, 0, 0, 1, 1, 6'd22);    step();
        disp(7'b0010011, 3'b111, 0, 6'd4, 0, 0, 0, 0, 0, 1, 2, 6'd23);    step();
        idle();
        chk("ord_count3", count, 3);
        bcast(4, 40); step(); idle();
        step(); chk("ord_b_pd", issue_pd, 22); chk("ord_count2", count, 2);
        step(); chk("ord_c_pd", issue_pd, 23); chk("ord_count1", count, 1);
        bcast(3, 30); step(); idle();
        step(); chk("ord_a_pd", issue_pd, 21); chk("ord_count0", count, 0);

        // Fill to capacity on tag 5, then drain and reset mid-drain
        for (int i = 0; i < DEPTH; i++) begin
            disp(7'b0010011, 3'b000, 0, 6'd5, 0, 0, 0, 0, 0, 1, i, 6'(i + 1));
            step();
        end
        chk("full_count", count, 16);
        chk("full_ready", disp_ready, 0);
        disp(7'b0010011, 3'b000, 0, 6'd1, 1, 1, 0, 0, 0, 1, 1, 6'd30);
        step(); idle();
        chk("full_reject", count, 16);
        bcast(5, 55); step(); idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_pd", issue_pd, i + 1);
        end
        reset = 1; step(); reset = 0;
        chk("midrst_count", count, 0);
        chk("midrst_valid", issue_valid, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            int k;
            idle();
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) < 7) begin
                k = $urandom_range(0, 7);
                disp(ops[k], f3s[k], f7s[k],
                     6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                     6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                     k >= 4, $urandom, (k == 7) ? 6'd0 : 6'($urandom_range(1, 63)));
            end
            if ($urandom_range(0, 1) == 1) bcast(6'($urandom_range(0, 7)), $urandom);
            step();
        end
        reset = 0;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
